mdu_iter: RTL and testbench

//  Parametrised multiply/divide unit for the E stage; successor to the fixed 32-bit HI/LO unit.

---
 rtl/mdu_iter_if.sv | 25 ++
 rtl/mdu_iter.sv | 178 +++++++++++++++++
 tb/tb_mdu_iter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Handshake/result bundle between the E stage and the iterative multiply/divide unit.
// The pipeline side uses the master modport, the MDU the slave modport.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, rs_val, rt_val, flush,
    input  start, busy, hi, lo
  );

  modport slave (
    input  op_valid, op_code, rs_val, rt_val, flush,
    output start, busy, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: fixed-latency multiply, WIDTH-step restoring divide.
// Define MDU_MAC_EN to enable the multiply-accumulate codes 7..10 (MADD/MADDU/MSUB/MSUBU).
module mdu_iter #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic     clk,
  input  logic     reset,
  mdu_iter_if.slave bus
);

  localparam int CNT_MAX = (WIDTH > MULT_LAT) ? WIDTH : MULT_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
`ifdef MDU_MAC_EN
  logic [1:0]         r_mac_op;
`endif

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_accept;
  logic               w_signed_mul;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  always_comb begin
    w_is_mul     = (bus.op_code == 4'd1) || (bus.op_code == 4'd2);
    w_signed_mul = (bus.op_code == 4'd1);
`ifdef MDU_MAC_EN
    w_is_mul     = w_is_mul || ((bus.op_code >= 4'd7) && (bus.op_code <= 4'd10));
    w_signed_mul = w_signed_mul || (bus.op_code == 4'd7) || (bus.op_code == 4'd9);
`endif
    w_is_div     = (bus.op_code == 4'd3) || (bus.op_code == 4'd4);
    w_accept     = bus.op_valid && (r_state == S_IDLE) && !bus.flush;
  end

  // Sign-extending to 2*WIDTH makes one truncated multiply correct for both signednesses.
  always_comb begin
    w_a_ext = {{WIDTH{w_signed_mul & bus.rs_val[WIDTH-1]}}, bus.rs_val};
    w_b_ext = {{WIDTH{w_signed_mul & bus.rt_val[WIDTH-1]}}, bus.rt_val};
    w_prod  = w_a_ext * w_b_ext;
    w_a_neg = (bus.op_code == 4'd3) && bus.rs_val[WIDTH-1];
    w_b_neg = (bus.op_code == 4'd3) && bus.rt_val[WIDTH-1];
    w_a_mag = w_a_neg ? -bus.rs_val : bus.rs_val;
    w_b_mag = w_b_neg ? -bus.rt_val : bus.rt_val;
  end

  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_divisor};
    w_fits  = !w_diff[WIDTH];
    // MIN / -1 falls out naturally: magnitude 2^(WIDTH-1) negates back to MIN, remainder 0.
    w_q_fix = r_divzero ? {WIDTH{1'b1}} : (r_q_neg ? -r_quo : r_quo);
    w_r_fix = r_r_neg ? -r_rem : r_rem;
  end

  always_comb begin
    w_mul_res = r_prod;
`ifdef MDU_MAC_EN
    if (r_mac_op == 2'd1) w_mul_res = {r_hi, r_lo} + r_prod;
    else if (r_mac_op == 2'd2) w_mul_res = {r_hi, r_lo} - r_prod;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next = S_MUL;
        else if (w_accept && w_is_div) w_next = S_DIV;
      end
      S_MUL:   if (r_cnt == '0) w_next = S_IDLE;
      S_DIV:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.start = bus.op_valid && (w_is_mul || w_is_div);
    bus.busy  = (r_state != S_IDLE);
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_prod    <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_divzero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef MDU_MAC_EN
      r_mac_op  <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_prod <= w_prod;
            r_cnt  <= MUL_LOAD;
`ifdef MDU_MAC_EN
            if ((bus.op_code == 4'd7) || (bus.op_code == 4'd8))       r_mac_op <= 2'd1;
            else if ((bus.op_code == 4'd9) || (bus.op_code == 4'd10)) r_mac_op <= 2'd2;
            else                                                      r_mac_op <= 2'd0;
`endif
          end else if (w_accept && w_is_div) begin
            r_quo     <= w_a_mag;
            r_rem     <= '0;
            r_divisor <= w_b_mag;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            r_divzero <= (bus.rt_val == '0);
            r_cnt     <= DIV_LOAD;
          end else if (w_accept && (bus.op_code == 4'd5)) begin
            r_hi <= bus.rs_val;
          end else if (w_accept && (bus.op_code == 4'd6)) begin
            r_lo <= bus.rs_val;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) {r_hi, r_lo} <= w_mul_res;
          else             r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_lo <= w_q_fix;
          r_hi <= w_r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32, MULT_LAT=5).
// MAC scenarios run only when MDU_MAC_EN is defined; otherwise codes 7..15 are checked as NOPs.
module tb_mdu_iter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32), .MULT_LAT(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Presents one op for a single accept edge, then counts cycles with busy high (bounded).
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        output logic st, output int cyc);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.rs_val   = a;
    bus.rt_val   = b;
    #1 st = bus.start;
    @(negedge clk);
    bus.op_valid = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.op_valid = 1'b0; bus.op_code = 4'd0; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
    #1 reset = 1'b0;
    #2;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult;
    logic st; int cyc;
    run_op(4'd5, 32'h0000_1234, 32'h0, st, cyc);
    run_op(4'd6, 32'h0000_5678, 32'h0, st, cyc);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 4'd1; bus.rs_val = 32'hFFFF_FFFD; bus.rt_val = 32'd7;
    #1;
    checks++; if (bus.start !== 1'b1) begin errors++; $display("[TB] FAIL mult_start: got %b expected 1", bus.start); end
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("[TB] FAIL mult_hold_hi: got %h expected %h", bus.hi, 32'h0000_1234); end
    checks++; if (bus.lo !== 32'h0000_5678) begin errors++; $display("[TB] FAIL mult_hold_lo: got %h expected %h", bus.lo, 32'h0000_5678); end
    cyc = 2;
    while (bus.busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    checks++; if (cyc !== 6) begin errors++; $display("[TB] FAIL mult_busy_cycles: got %0d expected %0d", cyc - 1, 5); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected %h", bus.hi, 32'hFFFF_FFFF); end
    checks++; if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL mult_lo: got %h expected %h", bus.lo, 32'hFFFF_FFEB); end
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, st, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected %0d", cyc, 5); end
    checks++; if (bus.hi !== 32'h0000_0001) begin errors++; $display("[TB] FAIL multu_hi: got %h expected %h", bus.hi, 32'h1); end
    checks++; if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_lo: got %h expected %h", bus.lo, 32'hFFFF_FFFE); end
  endtask

  task automatic test_div;
    logic st; int cyc;
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, st, cyc);
    checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL div_start: got %b expected 1", st); end
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL div_busy_cycles: got %0d expected %0d", cyc, 33); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected %h", bus.lo, 32'hFFFF_FFFD); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected %h", bus.hi, 32'hFFFF_FFFF); end
    run_op(4'd3, 32'd7, 32'hFFFF_FFFE, st, cyc);
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_negdivisor_lo: got %h expected %h", bus.lo, 32'hFFFF_FFFD); end
    checks++; if (bus.hi !== 32'h0000_0001) begin errors++; $display("[TB] FAIL div_negdivisor_hi: got %h expected %h", bus.hi, 32'h1); end
    run_op(4'd4, 32'd100, 32'd7, st, cyc);
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL divu_lo: got %h expected %h", bus.lo, 32'd14); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL divu_hi: got %h expected %h", bus.hi, 32'd2); end
  endtask

  task automatic test_div_special;
    logic st; int cyc;
    run_op(4'd4, 32'd100, 32'd0, st, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL divzero_busy_cycles: got %0d expected %0d", cyc, 33); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divuzero_lo: got %h expected %h", bus.lo, 32'hFFFF_FFFF); end
    checks++; if (bus.hi !== 32'd100) begin errors++; $display("[TB] FAIL divuzero_hi: got %h expected %h", bus.hi, 32'd100); end
    run_op(4'd3, 32'hFFFF_FFFB, 32'd0, st, cyc);
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divzero_lo: got %h expected %h", bus.lo, 32'hFFFF_FFFF); end
    checks++; if (bus.hi !== 32'hFFFF_FFFB) begin errors++; $display("[TB] FAIL divzero_hi: got %h expected %h", bus.hi, 32'hFFFF_FFFB); end
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, st, cyc);
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("[TB] FAIL divovf_lo: got %h expected %h", bus.lo, 32'h8000_0000); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL divovf_hi: got %h expected %h", bus.hi, 32'h0); end
  endtask

  task automatic test_mt_flush;
    logic st; int cyc;
    run_op(4'd6, 32'd9, 32'd0, st, cyc);
    bus.flush = 1'b1;
    run_op(4'd6, 32'd5, 32'd0, st, cyc);
    bus.flush = 1'b0;
    checks++; if (bus.lo !== 32'd9) begin errors++; $display("[TB] FAIL mtlo_flushed: got %h expected %h", bus.lo, 32'd9); end
    run_op(4'd6, 32'd5, 32'd0, st, cyc);
    checks++; if (bus.lo !== 32'd5) begin errors++; $display("[TB] FAIL mtlo: got %h expected %h", bus.lo, 32'd5); end
    checks++; if (cyc !== 0) begin errors++; $display("[TB] FAIL mtlo_busy_cycles: got %0d expected %0d", cyc, 0); end
    checks++; if (st !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_start: got %b expected 0", st); end
  endtask

  task automatic test_flush_busy;
    logic st; int cyc;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 4'd2; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.flush = 1'b1;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    bus.flush = 1'b0;
    checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL flush_busy_cycles: got %0d expected %0d", cyc, 5); end
    checks++; if (bus.lo !== 32'd42) begin errors++; $display("[TB] FAIL flush_busy_lo: got %h expected %h", bus.lo, 32'd42); end
  endtask

  task automatic test_back_to_back;
    logic st; int cyc;
    run_op(4'd5, 32'h55, 32'd0, st, cyc);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 4'd2; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.op_code = 4'd5; bus.rs_val = 32'hAA;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL b2b_hi_product: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'd6) begin errors++; $display("[TB] FAIL b2b_lo_product: got %h expected %h", bus.lo, 32'd6); end
    @(negedge clk);
    bus.op_valid = 1'b0;
    checks++; if (bus.hi !== 32'hAA) begin errors++; $display("[TB] FAIL b2b_mthi_next: got %h expected %h", bus.hi, 32'hAA); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 4'd2; bus.rs_val = 32'd4; bus.rt_val = 32'd4;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL midreset_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL midreset_lo: got %h expected %h", bus.lo, 32'h0); end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL midreset_no_resume: got %h expected %h", bus.lo, 32'h0); end
  endtask

`ifdef MDU_MAC_EN
  task automatic test_mac;
    logic st; int cyc;
    run_op(4'd5, 32'd0, 32'd0, st, cyc);
    run_op(4'd6, 32'd10, 32'd0, st, cyc);
    run_op(4'd8, 32'd3, 32'd4, st, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL maddu_busy_cycles: got %0d expected %0d", cyc, 5); end
    checks++; if (bus.lo !== 32'd22) begin errors++; $display("[TB] FAIL maddu_lo: got %h expected %h", bus.lo, 32'd22); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL maddu_hi: got %h expected %h", bus.hi, 32'd0); end
    run_op(4'd6, 32'd0, 32'd0, st, cyc);
    run_op(4'd9, 32'd1, 32'd1, st, cyc);
    checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL msub_start: got %b expected 1", st); end
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL msub_hilo: got %h expected %h", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF); end
  endtask
`else
  task automatic test_nop_codes;
    logic st; int cyc;
    run_op(4'd5, 32'h11, 32'd0, st, cyc);
    run_op(4'd6, 32'h22, 32'd0, st, cyc);
    run_op(4'd7, 32'd3, 32'd4, st, cyc);
    checks++; if (st !== 1'b0) begin errors++; $display("[TB] FAIL madd_nop_start: got %b expected 0", st); end
    checks++; if (cyc !== 0) begin errors++; $display("[TB] FAIL madd_nop_busy: got %0d expected %0d", cyc, 0); end
    run_op(4'd12, 32'd3, 32'd4, st, cyc);
    run_op(4'd0, 32'd3, 32'd4, st, cyc);
    checks++; if (bus.hi !== 32'h11) begin errors++; $display("[TB] FAIL nop_hi: got %h expected %h", bus.hi, 32'h11); end
    checks++; if (bus.lo !== 32'h22) begin errors++; $display("[TB] FAIL nop_lo: got %h expected %h", bus.lo, 32'h22); end
  endtask
`endif

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_special;
    test_mt_flush;
    test_flush_busy;
    test_back_to_back;
    test_reset_mid;
`ifdef MDU_MAC_EN
    test_mac;
`else
    test_nop_codes;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
